// File: rtl/clz_pkg.sv
// Shared definitions for the count-leading/trailing-zeros/ones pipeline:
// operation encodings and the width of the count result.
package clz_pkg;

    // Operation selector carried with each operand.
    // Bit 1 selects counting ones (operand is inverted).
    // Bit 0 selects counting from the LSB (operand is bit-reversed).
    typedef enum logic [1:0] {
        MODE_CLZ = 2'b00,
        MODE_CTZ = 2'b01,
        MODE_CLO = 2'b10,
        MODE_CTO = 2'b11
    } mode_e;

    // A count can run from 0 to WIDTH inclusive, so it needs one bit more
    // than log2(WIDTH).
    function automatic int pos_width(input int width);
        return $clog2(width) + 1;
    endfunction

    // Width of a per-slice local count (0..CHUNK inclusive).
    function automatic int slice_count_width(input int chunk);
        return $clog2(chunk) + 1;
    endfunction

endpackage

// File: rtl/clz_slice.sv
// Combinational leading-zero counter for one CHUNK-wide slice.
// Produces the number of leading zeros (CHUNK when the slice is empty)
// and a flag telling the merge stage that the slice holds no set bit.
module clz_slice
    import clz_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]       data,
    output logic [$clog2(CHUNK):0] count,
    output logic                   zero
);

    localparam int SW = slice_count_width(CHUNK);

    // Scan from the LSB upward; the last set bit seen is the most
    // significant one, so its position wins the count.
    always_comb begin
        count = SW'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (data[i]) begin
                count = SW'(CHUNK - 1 - i);
            end
        end
    end

    assign zero = ~|data;

endmodule

// File: rtl/clz_pipe.sv
// Two-stage pipelined CLZ/CTZ/CLO/CTO counter with valid/ready handshake.
//
// Stage 1 transforms the operand (invert for ones-counting, reverse for
// trailing counts) and registers a local leading-zero count plus an
// all-zero flag for every CHUNK slice, together with the mode.
// Stage 2 merges the slice results into the final count.
//
// The bit reversal for trailing modes is split: each slice is reversed
// locally in stage 1, and stage 2 walks the slices from the bottom of the
// word instead of the top. That yields exactly the slices of the fully
// reversed word, just stored at their physical positions, and saves a
// full-width crossbar in front of the slice counters.
module clz_pipe
    import clz_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             data_in,
    input  logic [1:0]                   mode_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [pos_width(WIDTH)-1:0]  pos_out,
    output logic                         all_out
);

    localparam int NS = WIDTH / CHUNK;
    localparam int SW = slice_count_width(CHUNK);
    localparam int PW = pos_width(WIDTH);
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s2_ready;
    logic s1_ready;
    logic accept;

    // A stage can take new data when it is empty or its content leaves
    // this cycle. Nothing here looks at in_valid, so in_ready carries no
    // combinational path from it.
    assign s2_ready = !s2_valid_reg || out_ready;
    assign s1_ready = !s1_valid_reg || s2_ready;
    assign in_ready = s1_ready && !rst;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1 input transform and slice counters
    // ------------------------------------------------------------------
    mode_e            mode_sel;
    logic             ones_in;
    logic             trail_in;
    logic [WIDTH-1:0] inv_word;
    logic [CHUNK-1:0] slice_in   [NS];
    logic [SW-1:0]    slice_cnt  [NS];
    logic             slice_zero [NS];

    // Reverse the bit order of one slice.
    function automatic logic [CHUNK-1:0] rev_chunk(input logic [CHUNK-1:0] v);
        logic [CHUNK-1:0] r;
        r = '0;
        for (int i = 0; i < CHUNK; i++) begin
            r[i] = v[CHUNK-1-i];
        end
        return r;
    endfunction

    assign mode_sel = mode_e'(mode_in);
    assign ones_in  = (mode_sel == MODE_CLO) || (mode_sel == MODE_CTO);
    assign trail_in = (mode_sel == MODE_CTZ) || (mode_sel == MODE_CTO);
    assign inv_word = data_in ^ {WIDTH{ones_in}};

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_slice
            assign slice_in[gi] = trail_in ? rev_chunk(inv_word[gi*CHUNK +: CHUNK])
                                           : inv_word[gi*CHUNK +: CHUNK];

            clz_slice #(
                .CHUNK (CHUNK)
            ) u_slice (
                .data  (slice_in[gi]),
                .count (slice_cnt[gi]),
                .zero  (slice_zero[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [SW-1:0] s1_cnt_reg  [NS];
    logic          s1_zero_reg [NS];
    mode_e         s1_mode_reg;

    // Capture slice results on acceptance; hold while stage 2 is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= MODE_CLZ;
            for (int i = 0; i < NS; i++) begin
                s1_cnt_reg[i]  <= '0;
                s1_zero_reg[i] <= 1'b0;
            end
        end else if (s1_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_mode_reg <= mode_sel;
                for (int i = 0; i < NS; i++) begin
                    s1_cnt_reg[i]  <= slice_cnt[i];
                    s1_zero_reg[i] <= slice_zero[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 merge
    // ------------------------------------------------------------------
    logic          s1_trail;
    logic          found;
    logic [IW-1:0] idx;
    logic [PW-1:0] pos_next;
    logic          all_next;

    // Walk slices in transformed-word order (top-down for leading modes,
    // bottom-up for trailing modes); the first non-empty slice ends the
    // count, each empty slice before it contributes CHUNK.
    always_comb begin
        s1_trail = (s1_mode_reg == MODE_CTZ) || (s1_mode_reg == MODE_CTO);
        pos_next = PW'(WIDTH);
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NS; k++) begin
            idx = s1_trail ? IW'(k) : IW'(NS - 1 - k);
            if (!found && !s1_zero_reg[idx]) begin
                pos_next = PW'(k * CHUNK) + PW'(s1_cnt_reg[idx]);
                found    = 1'b1;
            end
        end
        all_next = !found;
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (output stage)
    // ------------------------------------------------------------------
    logic [PW-1:0] pos_reg;
    logic          all_reg;

    // Result only updates when the consumer is free, so it stays stable
    // throughout an output stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            pos_reg      <= '0;
            all_reg      <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                pos_reg <= pos_next;
                all_reg <= all_next;
            end
        end
    end

    // Outputs are forced quiet for the whole time reset is held, including
    // the cycle before the first reset edge has been sampled.
    assign out_valid = s2_valid_reg && !rst;
    assign pos_out   = rst ? '0 : pos_reg;
    assign all_out   = all_reg && !rst;

endmodule

// File: doc/clz_pipe.md
CLZ_PIPE -- requirements
Module: clz_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand width; SHALL be a power of two, 8..64.
REQ-002 Parameter CHUNK, default 8: stage-1 slice width; SHALL be a power of two dividing WIDTH.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand offered.
REQ-006 in_ready  output  1  operand accepted when in_valid && in_ready.
REQ-007 data_in  input  WIDTH  operand.
REQ-008 mode_in  input  2  operation: 00 CLZ, 01 CTZ, 10 CLO, 11 CTO.
REQ-009 out_valid  output  1  result presented.
REQ-010 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 pos_out  output  $clog2(WIDTH)+1  count result.
REQ-012 all_out  output  1  set when no bit terminated the count (pos_out == WIDTH).

Function
REQ-013 Transform: CLO/CTO SHALL invert data_in; CTZ/CTO SHALL bit-reverse it; then count leading zeros of the transformed word.
REQ-014 Stage 1 SHALL register, per CHUNK slice, its local leading-zero count and an all-zero flag, plus the mode.
REQ-015 Stage 2 SHALL register pos_out = CHUNK*(number of leading all-zero slices) + local count of first non-zero slice; WIDTH if all slices are zero.
REQ-016 all_out SHALL equal (pos_out == WIDTH) on every valid result.
REQ-017 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-018 Throughput SHALL be one result per cycle with out_ready held high; no bubbles.
REQ-019 Stall: stage s SHALL advance iff it is empty or the stage downstream advances; in_ready = !s1_valid || s1_advance.
REQ-020 While out_valid && !out_ready, pos_out and all_out SHALL stay stable.
REQ-021 Simultaneous accept at input and consume at output SHALL both take effect in the same cycle.
REQ-022 in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 Results SHALL emerge in acceptance order; none dropped or duplicated.
REQ-024 data_in and mode_in are sampled only on acceptance; values at other times have no effect.

Reset
REQ-025 While rst is high: stage valids, out_valid = 0; pos_out = 0; all_out = 0; in_ready = 0.
REQ-026 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-027 rst asserted mid-operation SHALL discard all in-flight operands; no result emitted for them.

Structure
REQ-028 Package clz_pkg SHALL hold the mode encodings (MODE_CLZ, MODE_CTZ, MODE_CLO, MODE_CTO) and the function computing the pos_out width.
REQ-029 Sub-module clz_slice (combinational, CHUNK-wide: local count + all-zero flag) SHALL be instantiated WIDTH/CHUNK times in stage 1.
REQ-030 No other sub-modules; pipeline registers and handshake live in clz_pipe.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-031 CLZ, data_in=0x00000000 -> pos_out=32, all_out=1 after 2 cycles; 0x80000000 -> 0; 0x00010000 -> 15.
REQ-032 Sweep CLZ over i=0..31 with bit i set, random lower bits, out_ready=1 -> pos_out=31-i each, one result per cycle.
REQ-033 Modes on 0x0000FF00: CLZ=16, CTZ=8, CLO=0, CTO=0; on 0xFFFFFFFF: CLO=32 all_out=1, CLZ=0.
REQ-034 Back-to-back 10 operands with out_ready toggling 1,0,0,1...: results in order, stable while stalled, in_ready low when both stages full.
REQ-035 Assert rst with 2 operands in flight -> no out_valid for them; in_ready=1 first cycle after release; next operand 0x00000001 -> 31.
REQ-036 WIDTH=64, CHUNK=16: 0x0000000100000000 CLZ -> 31; zero -> 64, all_out=1.
